// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard and forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks destination info for EX, MEM and WB, selects operand forwarding paths,
// inserts a single bubble for load-use hazards, flushes IF/ID on taken branches
// and implements a debug halt with a short drain phase plus saturating event counters.

module pipeline_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_id_ra,
    input  logic [3:0]       i_id_rb,
    input  logic [3:0]       i_id_rd,
    input  logic             i_id_use_ra,
    input  logic             i_id_use_rb,
    input  logic             i_id_use_rd,
    input  logic [3:0]       i_id_dest,
    input  logic             i_id_rf_e,
    input  logic             i_id_load,
    input  logic             i_branch_taken,
    input  logic             i_halt_req,
    output logic             o_pc_e,
    output logic             o_ifid_e,
    output logic             o_ifid_flush,
    output logic             o_nop_sel,
    output logic [1:0]       o_s_pa,
    output logic [1:0]       o_s_pb,
    output logic [1:0]       o_s_pd,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    // The drain counter only has to hold DRAIN_CYC-1, so size it to that.
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]       PC_REG     = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Forwarding select encodings shared by PA, PB and PD.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Shadow copies of the destination/write-enable info of the instructions
    // currently in EX, MEM and WB.
    logic [3:0]       r_ex_dest;
    logic             r_ex_rf_e;
    logic             r_ex_load;
    logic [3:0]       r_mem_dest;
    logic             r_mem_rf_e;
    logic [3:0]       r_wb_dest;
    logic             r_wb_rf_e;

    state_t           r_state;
    logic [DW-1:0]    r_drain_cnt;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic             w_run;
    logic             w_valid_a;
    logic             w_valid_b;
    logic             w_valid_d;
    logic             w_ex_hit_a;
    logic             w_ex_hit_b;
    logic             w_ex_hit_d;
    logic             w_stall;
    logic             w_flush;
    logic             w_freeze;

    // Picks the youngest in-flight producer of register r. R15 is the PC and
    // is never forwarded; an operand that is not read never forwards either.
    function automatic logic [1:0] f_fwd_sel(
        input logic [3:0] r,
        input logic       use_r,
        input logic [3:0] ex_dest,
        input logic       ex_rf_e,
        input logic [3:0] mem_dest,
        input logic       mem_rf_e,
        input logic [3:0] wb_dest,
        input logic       wb_rf_e
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_r && (r != PC_REG)) begin
            if (ex_rf_e && (ex_dest == r)) begin
                sel = FWD_EX;
            end else if (mem_rf_e && (mem_dest == r)) begin
                sel = FWD_MEM;
            end else if (wb_rf_e && (wb_dest == r)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    assign w_run = (r_state == ST_RUN);

    // An operand takes part in hazard/forwarding decisions only when it is
    // actually read and is not the PC.
    assign w_valid_a = i_id_use_ra && (i_id_ra != PC_REG);
    assign w_valid_b = i_id_use_rb && (i_id_rb != PC_REG);
    assign w_valid_d = i_id_use_rd && (i_id_rd != PC_REG);

    assign w_ex_hit_a = w_valid_a && (i_id_ra == r_ex_dest);
    assign w_ex_hit_b = w_valid_b && (i_id_rb == r_ex_dest);
    assign w_ex_hit_d = w_valid_d && (i_id_rd == r_ex_dest);

    // A load in EX cannot supply its data yet, so a dependent ID instruction
    // waits one cycle and then picks the value up from MEM.
    assign w_stall = w_run && r_ex_load && r_ex_rf_e &&
                     (w_ex_hit_a || w_ex_hit_b || w_ex_hit_d);

    // A stalled ID instruction has not really executed, so its branch decision
    // is discarded and made again once the stall clears.
    assign w_flush = w_run && i_branch_taken && !w_stall;

    // Both a load-use stall and any non-RUN state freeze the front end and
    // feed bubbles into EX.
    assign w_freeze = w_stall || !w_run;

    assign o_pc_e        = !w_freeze;
    assign o_ifid_e      = !w_freeze;
    assign o_nop_sel     = w_freeze;
    assign o_ifid_flush  = w_flush;
    assign o_halted      = r_halted;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

    assign o_s_pa = f_fwd_sel(i_id_ra, i_id_use_ra, r_ex_dest, r_ex_rf_e,
                              r_mem_dest, r_mem_rf_e, r_wb_dest, r_wb_rf_e);
    assign o_s_pb = f_fwd_sel(i_id_rb, i_id_use_rb, r_ex_dest, r_ex_rf_e,
                              r_mem_dest, r_mem_rf_e, r_wb_dest, r_wb_rf_e);
    assign o_s_pd = f_fwd_sel(i_id_rd, i_id_use_rd, r_ex_dest, r_ex_rf_e,
                              r_mem_dest, r_mem_rf_e, r_wb_dest, r_wb_rf_e);

    // Advance the shadow pipeline each cycle; EX receives a bubble whenever
    // the CU mux is zeroing the ID control signals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_dest  <= 4'd0;
            r_ex_rf_e  <= 1'b0;
            r_ex_load  <= 1'b0;
            r_mem_dest <= 4'd0;
            r_mem_rf_e <= 1'b0;
            r_wb_dest  <= 4'd0;
            r_wb_rf_e  <= 1'b0;
        end else begin
            r_mem_dest <= r_ex_dest;
            r_mem_rf_e <= r_ex_rf_e;
            r_wb_dest  <= r_mem_dest;
            r_wb_rf_e  <= r_mem_rf_e;
            if (w_freeze) begin
                r_ex_dest <= 4'd0;
                r_ex_rf_e <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_dest <= i_id_dest;
                r_ex_rf_e <= i_id_rf_e;
                r_ex_load <= i_id_load;
            end
        end
    end

    // Debug halt: drain the back end with bubbles, then hold until released;
    // dropping the request at any point returns to RUN on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_halted <= 1'b0;
                    if (i_halt_req) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    if (!i_halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end else if (r_drain_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DW'(1);
                    end
                end
                ST_HALTED: begin
                    if (!i_halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Saturating event counters for load-use stall cycles and IF/ID flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

endmodule
